pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline control unit for the 4-stage core (IF, ID, EX, MEM/WB) built around the `pipeline3` execute stage. It detects RAW hazards between ID and EX, and waits on multi-cycle MUL/DIV completion and on memory acknowledge. It flushes the front end when EX redirects the PC. It drives the stall, bubble, flush and operand-forward controls of the pipeline registers.

## Interface
Parameters:
- `CTRL_WIDTH`, `REG_ADDR_WIDTH`: default from `params_proc.v`; opcode and register-address widths.
- `FLUSH_CYC`: default 1; number of cycles `flush` is asserted per redirect, range 1..4.
- `MAX_WAIT`: default 255; watchdog limit in cycles for MUL/DIV or memory waits.

Ports:
- `clk_in`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_ctrl`  in  CTRL_WIDTH  opcode in ID.
- `id_A_addr`, `id_B_addr`  in  REG_ADDR_WIDTH  ID source registers.
- `ex_ctrl`, `ex_reg_addr`  in  CTRL_WIDTH / REG_ADDR_WIDTH  instruction in EX (ID/EX register).
- `mem_ctrl`  in  CTRL_WIDTH  instruction in MEM (`pipeline3` `ctrl_out`).
- `ex_done`  in  1  `pipeline3` `done`.
- `pc_chg`  in  1  EX redirect.
- `mem_ack`  in  1  data memory completed the access.
- `stall_if`, `stall_id`, `stall_ex`  out  1  hold the PC, IF/ID and ID/EX registers.
- `bubble_ex`  out  1  load NOP into ID/EX.
- `bubble_mem`  out  1  load NOP into EX/MEM.
- `flush`  out  1  squash IF/ID and ID/EX.
- `fwd_a`, `fwd_b`  out  1  EX operand takes the EX/MEM result.
- `err`  out  1  watchdog fired (sticky).
- `state`  out  3  current FSM state (debug).

## Operation
Opcode classes:
- Writers: LW ADD SUB MUL DIV AND OR NOT.
- Reads A: all opcodes except JPC RET NOP.
- Reads B: SW ADD SUB MUL DIV AND OR CMP.

Register-file and hazard rules:
- The register file writes at the end of MEM/WB and is write-through. Only ID-vs-EX distance hazards exist.
- Register 0 is not special.

FSM states: RUN, MULDIV, MEM_WAIT, FLUSH. Outputs are Mealy; the state and counters are registered.

Priority in RUN, highest first:
1. `mem_ctrl` in {LW,SW} and !`mem_ack`: assert `stall_if`, `stall_id` and `stall_ex`; go to MEM_WAIT.
2. `ex_ctrl` in {MUL,DIV} and !`ex_done`: assert all three stalls and `bubble_mem`; go to MULDIV.
3. `pc_chg`: assert `flush`. If FLUSH_CYC>1, go to FLUSH with the counter set to FLUSH_CYC-1.
4. Hazard, meaning `id_valid`, EX is a writer, and a used ID source equals `ex_reg_addr`:
   - If EX is LW, assert `stall_if`, `stall_id` and `bubble_ex` for one cycle.
   - Otherwise forwarding resolves it (see Configuration).

Wait states:
- MEM_WAIT and MULDIV hold their stalls until `mem_ack` / `ex_done` is seen. Release is in the same cycle, and the state returns to RUN.
- `wait_cnt` increments each cycle spent in a wait state. When it reaches MAX_WAIT: set `err`, release the stalls, return to RUN.

Other rules:
- FLUSH: assert `flush` and decrement the counter; at 0 return to RUN. While in FLUSH, ignore `pc_chg` and hazards.
- `fwd_a`/`fwd_b` are registered. They load on each edge where !`stall_ex` with the EX-writer match for the ID operand. They hold while `stall_ex` and clear on `flush` or `bubble_ex`.

## Timing
- Reset: state=RUN, `wait_cnt`=0, `err`=0, `fwd_a`=`fwd_b`=0. All combinational outputs are 0 once their inputs are idle.
- Reset mid-wait: immediate return to RUN, with stalls released asynchronously.
- Load-use costs exactly 1 bubble.
- A MUL/DIV with `done` after k cycles stalls k cycles.
- Redirect penalty is FLUSH_CYC cycles.
- A simultaneous memory wait and `pc_chg` is resolved by rule 1. The flush happens on the cycle `mem_ack` releases, because `pc_chg` is still held by the EX stall.
- Combinational paths allowed: inputs to `stall_*`, `bubble_*` and `flush`.

## Configuration
`PIPE_CTRL_FWD_EN`:
- Defined: non-LW EX-writer hazards set `fwd_a`/`fwd_b` and do not stall.
- Undefined: every EX-writer hazard takes the one-cycle stall with `bubble_ex`, and `fwd_a`/`fwd_b` are tied to 0.

## Structure
- `pipe_ctrl_params.v`, included next to `params_proc.v`, holds:
  - state encodings;
  - the `is_writer`, `reads_a`, `reads_b` functions;
  - the watchdog counter width, `$clog2(MAX_WAIT+1)`.
- One combinational sub-module, `hazard_detect`: ID sources against the EX destination, producing `hz_a`, `hz_b` and `ex_is_load`.

## Test plan
- EX=ADD dst 5, ID=SUB A=5 B=9, FWD_EN defined -> no stall, `fwd_a`=1 next cycle, `fwd_b`=0. Without FWD_EN -> 1 cycle of `stall_id` and `bubble_ex`.
- EX=LW dst 7, ID=AND A=3 B=7 -> exactly 1 cycle of `stall_if`, `stall_id` and `bubble_ex`, then normal flow.
- EX=DIV, `ex_done` after 4 cycles -> `stall_ex` and `bubble_mem` for 4 cycles, state MULDIV, release on the `done` cycle.
- `mem_ctrl`=SW, `mem_ack` low 3 cycles while `pc_chg`=1 -> full stall 3 cycles, `flush` on the release cycle; with FLUSH_CYC=2, `flush` is high 2 cycles.
- `mem_ack` stuck low, MAX_WAIT=8 -> `err`=1 after 8 cycles, stalls drop, `err` stays set until `RST`.
- `RST` pulsed during MULDIV -> state=RUN, all outputs 0 at once.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode map, FSM encodings, control bundle and opcode-class helpers for pipe_ctrl.
package pipe_ctrl_pkg;

    localparam int CTRL_W = 4;
    localparam int REG_W  = 5;

    localparam logic [CTRL_W-1:0] OP_NOP = 4'd0,  OP_LW  = 4'd1,  OP_SW  = 4'd2,
                                  OP_ADD = 4'd3,  OP_SUB = 4'd4,  OP_MUL = 4'd5,
                                  OP_DIV = 4'd6,  OP_AND = 4'd7,  OP_OR  = 4'd8,
                                  OP_NOT = 4'd9,  OP_CMP = 4'd10, OP_JPC = 4'd11,
                                  OP_RET = 4'd12;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MULDIV   = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_FLUSH    = 3'd3
    } state_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic bubble_ex;
        logic bubble_mem;
        logic flush;
    } ctrl_t;

    function automatic logic is_writer(input logic [CTRL_W-1:0] op);
        case (op)
            OP_LW, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads_a(input logic [CTRL_W-1:0] op);
        case (op)
            OP_JPC, OP_RET, OP_NOP: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic reads_b(input logic [CTRL_W-1:0] op);
        case (op)
            OP_SW, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_CMP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int wd_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: compares the ID source registers with the EX destination (pure combinational).
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int CTRL_WIDTH     = CTRL_W,
    parameter int REG_ADDR_WIDTH = REG_W
) (
    input  logic                      id_valid,
    input  logic [CTRL_WIDTH-1:0]     id_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] id_A_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_B_addr,
    input  logic [CTRL_WIDTH-1:0]     ex_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_addr,
    output logic                      hz_a,
    output logic                      hz_b,
    output logic                      ex_is_load
);

    logic [CTRL_W-1:0] id_op, ex_op;
    logic              ex_wr;

    assign id_op      = CTRL_W'(id_ctrl);
    assign ex_op      = CTRL_W'(ex_ctrl);
    assign ex_wr      = id_valid && is_writer(ex_op);
    // register 0 is an ordinary register, so no zero-address exclusion
    assign hz_a       = ex_wr && reads_a(id_op) && (id_A_addr == ex_reg_addr);
    assign hz_b       = ex_wr && reads_b(id_op) && (id_B_addr == ex_reg_addr);
    assign ex_is_load = (ex_op == OP_LW);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/bubble/flush/forward control for the 4-stage core.
// Optional operand forwarding is enabled by defining PIPE_CTRL_FWD_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CTRL_WIDTH     = CTRL_W,
    parameter int REG_ADDR_WIDTH = REG_W,
    parameter int FLUSH_CYC      = 1,
    parameter int MAX_WAIT       = 255
) (
    input  logic                      clk_in,
    input  logic                      RST,
    input  logic                      id_valid,
    input  logic [CTRL_WIDTH-1:0]     id_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] id_A_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_B_addr,
    input  logic [CTRL_WIDTH-1:0]     ex_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_addr,
    input  logic [CTRL_WIDTH-1:0]     mem_ctrl,
    input  logic                      ex_done,
    input  logic                      pc_chg,
    input  logic                      mem_ack,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      stall_ex,
    output logic                      bubble_ex,
    output logic                      bubble_mem,
    output logic                      flush,
    output logic                      fwd_a,
    output logic                      fwd_b,
    output logic                      err,
    output logic [2:0]                state
);

    localparam int WCW = wd_width(MAX_WAIT);
`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    state_t         st, st_nxt;
    logic [WCW-1:0] wait_cnt, cnt_nxt;
    logic [1:0]     flush_cnt, fcnt_nxt;
    logic           err_set, run_eval, mask_wait;
    logic           hz_a, hz_b, ex_is_load, hz_stall, mem_wait, md_wait;
    logic [CTRL_W-1:0] ex_op, mem_op;
    ctrl_t          ctl, ctl_o;

    hazard_detect #(.CTRL_WIDTH(CTRL_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hz (
        .id_valid    (id_valid),
        .id_ctrl     (id_ctrl),
        .id_A_addr   (id_A_addr),
        .id_B_addr   (id_B_addr),
        .ex_ctrl     (ex_ctrl),
        .ex_reg_addr (ex_reg_addr),
        .hz_a        (hz_a),
        .hz_b        (hz_b),
        .ex_is_load  (ex_is_load)
    );

    assign ex_op    = CTRL_W'(ex_ctrl);
    assign mem_op   = CTRL_W'(mem_ctrl);
    assign mem_wait = ((mem_op == OP_LW) || (mem_op == OP_SW)) && !mem_ack;
    assign md_wait  = ((ex_op == OP_MUL) || (ex_op == OP_DIV)) && !ex_done;
    assign hz_stall = (hz_a || hz_b) && (ex_is_load || !FWD_EN);

    always_comb begin
        ctl       = '0;
        st_nxt    = st;
        cnt_nxt   = wait_cnt;
        fcnt_nxt  = flush_cnt;
        err_set   = 1'b0;
        run_eval  = 1'b0;
        mask_wait = 1'b0;
        case (st)
            ST_RUN: run_eval = 1'b1;
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    run_eval = 1'b1;
                end else if (wait_cnt == WCW'(MAX_WAIT)) begin
                    run_eval  = 1'b1;
                    mask_wait = 1'b1;
                    err_set   = 1'b1;
                end else begin
                    ctl.stall_if = 1'b1;
                    ctl.stall_id = 1'b1;
                    ctl.stall_ex = 1'b1;
                    cnt_nxt      = wait_cnt + WCW'(1);
                end
            end
            ST_MULDIV: begin
                if (ex_done) begin
                    run_eval = 1'b1;
                end else if (wait_cnt == WCW'(MAX_WAIT)) begin
                    run_eval  = 1'b1;
                    mask_wait = 1'b1;
                    err_set   = 1'b1;
                end else begin
                    ctl.stall_if   = 1'b1;
                    ctl.stall_id   = 1'b1;
                    ctl.stall_ex   = 1'b1;
                    ctl.bubble_mem = 1'b1;
                    cnt_nxt        = wait_cnt + WCW'(1);
                end
            end
            ST_FLUSH: begin
                ctl.flush = 1'b1;
                fcnt_nxt  = flush_cnt - 2'd1;
                if (flush_cnt == 2'd1) st_nxt = ST_RUN;
            end
            default: st_nxt = ST_RUN;
        endcase

        // a released wait re-evaluates the RUN priorities in the same cycle,
        // which is how a held pc_chg flushes on the mem_ack cycle
        if (run_eval) begin
            st_nxt  = ST_RUN;
            cnt_nxt = '0;
            if (!mask_wait && mem_wait) begin
                ctl.stall_if = 1'b1;
                ctl.stall_id = 1'b1;
                ctl.stall_ex = 1'b1;
                st_nxt       = ST_MEM_WAIT;
                cnt_nxt      = WCW'(1);
            end else if (!mask_wait && md_wait) begin
                ctl.stall_if   = 1'b1;
                ctl.stall_id   = 1'b1;
                ctl.stall_ex   = 1'b1;
                ctl.bubble_mem = 1'b1;
                st_nxt         = ST_MULDIV;
                cnt_nxt        = WCW'(1);
            end else if (pc_chg) begin
                ctl.flush = 1'b1;
                if (FLUSH_CYC > 1) begin
                    st_nxt   = ST_FLUSH;
                    fcnt_nxt = 2'(FLUSH_CYC - 1);
                end
            end else if (hz_stall) begin
                ctl.stall_if  = 1'b1;
                ctl.stall_id  = 1'b1;
                ctl.bubble_ex = 1'b1;
            end
        end
    end

    // reset releases every control line immediately, not at the next edge
    assign ctl_o      = RST ? '0 : ctl;
    assign stall_if   = ctl_o.stall_if;
    assign stall_id   = ctl_o.stall_id;
    assign stall_ex   = ctl_o.stall_ex;
    assign bubble_ex  = ctl_o.bubble_ex;
    assign bubble_mem = ctl_o.bubble_mem;
    assign flush      = ctl_o.flush;
    assign state      = st;

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            st        <= ST_RUN;
            wait_cnt  <= '0;
            flush_cnt <= '0;
            err       <= 1'b0;
        end else begin
            st        <= st_nxt;
            wait_cnt  <= cnt_nxt;
            flush_cnt <= fcnt_nxt;
            err       <= err | err_set;
        end
    end

`ifdef PIPE_CTRL_FWD_EN
    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            fwd_a <= 1'b0;
            fwd_b <= 1'b0;
        end else if (ctl_o.flush || ctl_o.bubble_ex) begin
            fwd_a <= 1'b0;
            fwd_b <= 1'b0;
        end else if (!ctl_o.stall_ex) begin
            fwd_a <= hz_a && !ex_is_load;
            fwd_b <= hz_b && !ex_is_load;
        end
    end
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

endmodule
